// File: rtl/tlp_tx_arbiter.sv
// Round-robin arbiter sharing one transceiver TLP write port between NUM_REQ requesters.
// Each granted TLP is tagged {index, payload}, followed by a holdoff and a ready wait.
module tlp_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int IDX_WIDTH     = 2,
  parameter int PAYLOAD_WIDTH = 54,
  parameter int HOLDOFF       = 3,
  parameter int TIMEOUT       = 4096
) (
  input  logic                               i_clk,
  input  logic                               i_arst_n,
  input  logic                               i_link_up,
  input  logic [NUM_REQ-1:0]                 i_req_valid,
  input  logic [NUM_REQ*PAYLOAD_WIDTH-1:0]   i_req_tlp,
  output logic [NUM_REQ-1:0]                 o_req_ack,
  input  logic                               i_tlp_rdy,
  output logic                               o_tlp_wr,
  output logic [PAYLOAD_WIDTH+IDX_WIDTH-1:0] o_tlp,
  input  logic                               i_err_clr,
  output logic                               o_err_timeout,
  output logic                               o_busy,
  output logic [1:0]                         o_dbg_state
);

  localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_HOLD     = 2'd1,
    S_WAIT_RDY = 2'd2
  } state_t;

  state_t                             r_state;
  logic [3:0]                         r_hold_cnt;
  logic [TO_W-1:0]                    r_to_cnt;
  logic [IDX_WIDTH-1:0]               r_last_grant;
  logic                               r_tlp_wr;
  logic [NUM_REQ-1:0]                 r_req_ack;
  logic [PAYLOAD_WIDTH+IDX_WIDTH-1:0] r_tlp;
  logic                               r_err;

  logic                               w_found;
  logic [IDX_WIDTH-1:0]               w_winner;
  logic [PAYLOAD_WIDTH-1:0]           w_payload;
  logic [NUM_REQ-1:0]                 w_ack;
  int                                 w_dist;
  int                                 w_best;

  // Winner = valid requester with the smallest rotational distance past last_grant.
  always_comb begin
    w_found   = 1'b0;
    w_winner  = '0;
    w_payload = '0;
    w_ack     = '0;
    w_best    = NUM_REQ;
    w_dist    = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_dist = (j + NUM_REQ - 1 - int'(r_last_grant)) % NUM_REQ;
      if (i_req_valid[j] && (w_dist < w_best)) begin
        w_best    = w_dist;
        w_found   = 1'b1;
        w_winner  = IDX_WIDTH'(j);
        w_payload = i_req_tlp[j*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
        w_ack     = NUM_REQ'(1) << j;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state      <= S_IDLE;
      r_hold_cnt   <= '0;
      r_to_cnt     <= '0;
      r_last_grant <= IDX_WIDTH'(NUM_REQ - 1);
      r_tlp_wr     <= 1'b0;
      r_req_ack    <= '0;
      r_tlp        <= '0;
      r_err        <= 1'b0;
    end else begin
      r_tlp_wr  <= 1'b0;
      r_req_ack <= '0;
      // A timeout set later in this block overrides the clear.
      if (i_err_clr) r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_link_up && i_tlp_rdy && w_found) begin
            r_tlp        <= {w_winner, w_payload};
            r_tlp_wr     <= 1'b1;
            r_req_ack    <= w_ack;
            r_last_grant <= w_winner;
            r_hold_cnt   <= 4'(HOLDOFF - 1);
            r_state      <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (r_hold_cnt == 4'd0) begin
            r_to_cnt <= '0;
            r_state  <= S_WAIT_RDY;
          end else begin
            r_hold_cnt <= r_hold_cnt - 4'd1;
          end
        end
        S_WAIT_RDY: begin
          if (i_tlp_rdy) begin
            r_state <= S_IDLE;
          end else begin
            if (r_to_cnt != TO_W'(TIMEOUT - 1)) r_to_cnt <= r_to_cnt + 1'b1;
            if (r_to_cnt >= TO_W'(TIMEOUT - 2)) r_err <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_tlp_wr      = r_tlp_wr;
  assign o_req_ack     = r_req_ack;
  assign o_tlp         = r_tlp;
  assign o_err_timeout = r_err;
  assign o_busy        = (r_state != S_IDLE);
  assign o_dbg_state   = r_state;

endmodule

// File: doc/tlp_tx_arbiter.md
# tlp_tx_arbiter

Shares the single TLP write port of one `lvds_transceiver_top` instance between `NUM_REQ` independent requesters. Arbitration is round-robin. Each granted TLP is tagged with the requester index in its top bits. The block sits on the transaction-layer write side, in the `i_tlp_wr_clk` domain, directly in front of `i_tlp_wr`/`i_tlp`/`o_tlp_rdy`. It issues exactly one write pulse per TLP, throttles on transceiver readiness and link status, and flags a stalled transceiver.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `IDX_WIDTH`, 2: requester index width, ≥ clog2(`NUM_REQ`).
- `PAYLOAD_WIDTH`, 54: payload bits per requester. `PAYLOAD_WIDTH` + `IDX_WIDTH` = transceiver `TLP_TX_WIDTH`.
- `HOLDOFF`, 3: cycles after a write pulse before `i_tlp_rdy` is sampled again, 1..15. Covers the transceiver-internal ready deassert latency.
- `TIMEOUT`, 4096: cycles in WAIT_RDY before `o_err_timeout` sets.
- `i_clk`  in  1  TLP write clock, the same clock as transceiver `i_tlp_wr_clk`.
- `i_arst_n`  in  1  asynchronous active-low reset.
- `i_link_up`  in  1  transceiver `o_status_connect`, already synchronised to `i_clk`.
- `i_req_valid`  in  `NUM_REQ`  per-requester request.
- `i_req_tlp`  in  `NUM_REQ`*`PAYLOAD_WIDTH`  payloads. Requester n occupies bits [n*`PAYLOAD_WIDTH` +: `PAYLOAD_WIDTH`].
- `o_req_ack`  out  `NUM_REQ`  one-hot, one-cycle acknowledge.
- `i_tlp_rdy`  in  1  transceiver `o_tlp_rdy`.
- `o_tlp_wr`  out  1  single-cycle write strobe to transceiver `i_tlp_wr`.
- `o_tlp`  out  `PAYLOAD_WIDTH`+`IDX_WIDTH`  data to transceiver, formatted as {index, payload}.
- `i_err_clr`  in  1  clears sticky error.
- `o_err_timeout`  out  1  sticky stall flag.
- `o_busy`  out  1  high in any state other than IDLE.

## Operation
- The state machine has three states: IDLE, HOLD and WAIT_RDY.
- **IDLE:** a grant occurs when `i_link_up`=1, `i_tlp_rdy`=1 and `i_req_valid` is nonzero.
  - The winner is the first valid requester found by searching upward from `last_grant`+1, modulo `NUM_REQ`.
  - Registered on the grant: `o_tlp`={winner index, winner payload}, `o_tlp_wr`=1, `o_req_ack`[winner]=1, `last_grant`=winner. Next state is HOLD with the counter set to `HOLDOFF`-1.
- **HOLD:**
  - `o_tlp_wr` and `o_req_ack` are low.
  - `o_tlp` holds its value.
  - The counter decrements each cycle. At 0 the state goes to WAIT_RDY and the timeout counter clears.
- **WAIT_RDY:**
  - When `i_tlp_rdy`=1, go to IDLE. No grant is issued in that same cycle.
  - Otherwise the timeout counter increments. When it reaches `TIMEOUT`-1, `o_err_timeout` sets.
  - The state remains WAIT_RDY while stalled. The block never issues a second write while the transceiver is not ready.
- Requester rules:
  - Payload and valid must be held stable until ack.
  - Valid may be withdrawn before ack; the request is then simply not considered.
  - Valid high in the cycle after ack counts as a new request.
- Link loss:
  - An in-flight HOLD/WAIT_RDY sequence completes normally.
  - No new grant is issued while `i_link_up`=0. Pending valids wait and are not dropped.
- Error flag:
  - `o_err_timeout` clears on `i_err_clr`.
  - If `i_err_clr` and a new timeout coincide, set wins.
- Reset values: `o_tlp_wr`=0, `o_req_ack`=0, `o_tlp`=0, `o_err_timeout`=0, `o_busy`=0, state=IDLE, `last_grant`=`NUM_REQ`-1 (so requester 0 wins first).
- Reset mid-operation: all outputs clear asynchronously and the in-flight handshake is abandoned. The transceiver must be reset in the same event.

## Timing
- Request to write latency: valid and ready in cycle 0 → `o_tlp_wr`, `o_tlp` and ack in cycle 1.
- Minimum spacing of write strobes: 1 + `HOLDOFF` + 1 cycles when `i_tlp_rdy` returns immediately. This is 5 cycles at default `HOLDOFF`=3.
- `o_tlp` is stable from the strobe cycle until the next grant.
- `o_busy` is high from the cycle after the grant (the strobe cycle) until the cycle WAIT_RDY exits.
- `o_req_ack` is high only in the strobe cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- **Single request:** after reset, requester 2 is valid with payload 0x00AB_CDEF, ready=1, link=1.
  - Required: one `o_tlp_wr` pulse 1 cycle later, `o_tlp`={2'd2, payload}, `o_req_ack`=4'b0100, `o_busy` high.
- **Round-robin fairness:** all 4 requesters continuously valid, `i_tlp_rdy` returns 1 cycle after HOLD.
  - Required: grant order 0,1,2,3,0,1; strobes exactly 5 cycles apart; no requester granted twice in any window of 4 grants.
- **Ready stall:** after a grant, hold `i_tlp_rdy`=0 for 10 cycles, then release.
  - Required: no second strobe while low; next grant in the cycle after IDLE is re-entered.
  - Required: with `TIMEOUT`=8, `o_err_timeout`=1 and stays set until `i_err_clr`.
- **Link gating:** `i_link_up`=0 with requesters 1 and 3 valid for 50 cycles.
  - Required: no strobe. After link rises: grant 1, then 3.
  - Required: link dropping during HOLD still completes WAIT_RDY without an extra strobe.
- **Withdraw and reset:** requester 0 withdraws valid while requester 1 is being serviced.
  - Required: requester 0 is never acked.
  - Assert `i_arst_n`=0 during HOLD. Required: all outputs 0 immediately; after release, requester 0 wins first.
